// File: rtl/uart_rx_arbiter_pkg.sv
// Shared definitions for the UART receive arbiter: default geometry and the
// tagged word layout that travels towards the AXI-readable RX FIFO.
package uart_arb_pkg;

   localparam int NUM_CH_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;
   localparam int CH_W       = $clog2(NUM_CH_DEF);

   typedef struct packed {
      logic [CH_W-1:0]       ch;
      logic [DATA_W_DEF-1:0] data;
   } tagged_word_t;

endpackage

// File: rtl/uart_rx_arbiter_if.sv
// Handshake bundle between the UART receivers, the arbiter and the RX FIFO.
// The master side is the arbiter; the slave side is the surrounding system.
interface uart_rx_arbiter_if #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 8
);

   localparam int CH_BITS = $clog2(NUM_CH);

   logic [NUM_CH-1:0]         ch_valid;
   logic [NUM_CH*DATA_W-1:0]  ch_data;
   logic [NUM_CH-1:0]         ch_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [CH_BITS+DATA_W-1:0] out_data;

   modport master (
      input  ch_valid,
      input  ch_data,
      input  out_ready,
      output ch_ready,
      output out_valid,
      output out_data
   );

   modport slave (
      output ch_valid,
      output ch_data,
      output out_ready,
      input  ch_ready,
      input  out_valid,
      input  out_data
   );

endinterface

// File: rtl/uart_rx_arbiter_rr.sv
// Rotating-priority arbiter: the search starts at the pointer and wraps, so
// the channel served last drops to lowest priority on the next round.
module rr_arbiter #(
   parameter int NUM_CH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         req,
   input  logic                      advance,
   output logic [NUM_CH-1:0]         grant,
   output logic [$clog2(NUM_CH)-1:0] grant_idx,
   output logic                      grant_valid
);

   localparam int IDX_W = $clog2(NUM_CH);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand;

   // Pick the first requester at ptr, ptr+1, ... wrapping naturally in IDX_W bits
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = ptr + IDX_W'(k);
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

   // Move priority just past the winner whenever a grant is actually taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && grant_valid) begin
         ptr <= grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_arbiter.sv
// Funnels the UART receivers into one tagged word stream for the PS read path,
// counts words delivered since the last acknowledge and raises a level irq on
// either a fill threshold or an idle timeout.
module uart_rx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_CH         = NUM_CH_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int IRQ_THRESH     = 16,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_rx_arbiter_if.master  bus,
   input  logic               irq_enable,
   input  logic               irq_ack,
   output logic               irq,
   output logic [CNT_W-1:0]   pending
);

   localparam int               IDX_W    = $clog2(NUM_CH);
   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [CNT_W-1:0] THRESH   = CNT_W'(IRQ_THRESH);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic              load;
   logic              handshake;
   logic [NUM_CH-1:0] grant;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_valid;
   logic [TMR_W-1:0]  idle_tmr;
   logic [TMR_W-1:0]  idle_tmr_next;
   logic              tmr_run;
   logic              timeout_flag;

   assign handshake = bus.out_valid & bus.out_ready;
   assign load      = ~bus.out_valid | bus.out_ready;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (bus.ch_valid),
      .advance     (load),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Pop strobe only when the output stage can take the byte; silent in reset
   assign bus.ch_ready = (load && rst_n) ? grant : '0;

   // One-entry output stage: refill on load, otherwise hold the word stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else if (load) begin
         if (grant_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= {grant_idx, bus.ch_data[int'(grant_idx)*DATA_W +: DATA_W]};
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

   // Words delivered since the last acknowledge; an ack coinciding with a delivery leaves one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else if (irq_ack) begin
         pending <= handshake ? CNT_W'(1) : '0;
      end else if (handshake && (pending != PEND_MAX)) begin
         pending <= pending + 1'b1;
      end
   end

   assign tmr_run       = ~handshake & ~irq_ack & (pending != '0);
   assign idle_tmr_next = (idle_tmr == TMR_LAST) ? idle_tmr : idle_tmr + 1'b1;

   // Idle timer counts quiet cycles with undelivered-status words; the flag latches until acknowledged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_tmr     <= '0;
         timeout_flag <= 1'b0;
      end else begin
         idle_tmr <= tmr_run ? idle_tmr_next : '0;
         if (irq_ack) begin
            timeout_flag <= 1'b0;
         end else if (tmr_run && (idle_tmr_next == TMR_LAST)) begin
            timeout_flag <= 1'b1;
         end
      end
   end

   // Registered level interrupt; status keeps accumulating while masked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else begin
         irq <= irq_enable & ((pending >= THRESH) | timeout_flag);
      end
   end

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Self-checking bench for uart_rx_arbiter: directed scenarios followed by a
// random phase, all compared against a rule-level model of the arbiter.
module tb_uart_rx_arbiter;
   import uart_arb_pkg::*;

   localparam int NCH = 8;
   localparam int DW  = 8;
   localparam int CW  = 8;
   localparam int THR = 16;
   localparam int TMO = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          irq_enable;
   logic          irq_ack;
   logic          irq;
   logic [CW-1:0] pending;

   uart_rx_arbiter_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

   uart_rx_arbiter #(
      .NUM_CH         (NCH),
      .DATA_W         (DW),
      .IRQ_THRESH     (THR),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .irq_enable (irq_enable),
      .irq_ack    (irq_ack),
      .irq        (irq),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [7:0]   bytes [NCH];
   int           force_ch = -1;
   logic [7:0]   force_val = 8'h00;

   // Reference state: what the arbiter should be holding, in plain terms
   int           m_ptr;
   bit           m_ov;
   tagged_word_t m_word;
   int           m_pend;
   int           m_idle;
   bit           m_flag;
   bit           m_irq;

   task automatic modelReset();
      m_ptr  = 0;
      m_ov   = 0;
      m_word = '0;
      m_pend = 0;
      m_idle = 0;
      m_flag = 0;
      m_irq  = 0;
   endtask

   // Winner is the requester at the smallest forward distance from the pointer
   function automatic int pickChannel(input logic [NCH-1:0] v, input int ptr);
      int best   = -1;
      int best_d = NCH;
      for (int i = 0; i < NCH; i++) begin
         if (v[i]) begin
            int d = (i - ptr + NCH) % NCH;
            if (d < best_d) begin
               best_d = d;
               best   = i;
            end
         end
      end
      return best;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic driveBytes();
      for (int i = 0; i < NCH; i++) begin
         bytes[i] = (i == force_ch) ? force_val : 8'($urandom_range(0, 255));
         bus.ch_data[i*DW +: DW] = bytes[i];
      end
   endtask

   // One clock of stimulus: drive, check the pop strobe, clock, advance model, check outputs
   task automatic applyStimulus(input logic [NCH-1:0] v, input logic rdy,
                                input logic en, input logic ack);
      logic [NCH-1:0] exp_ready;
      int  g;
      bit  load, hs, run, flag_n, irq_n;
      int  pend_n, idle_n;
      bus.ch_valid  = v;
      bus.out_ready = rdy;
      irq_enable    = en;
      irq_ack       = ack;
      driveBytes();
      load = !m_ov || rdy;
      hs   = m_ov && rdy;
      g    = pickChannel(v, m_ptr);
      exp_ready = '0;
      if (load && g >= 0) exp_ready[g] = 1'b1;
      #1;
      checkOutput("ch_ready", 32'(bus.ch_ready), 32'(exp_ready));
      @(posedge clk);
      irq_n = en && ((m_pend >= THR) || m_flag);
      if (ack)     pend_n = hs ? 1 : 0;
      else if (hs) pend_n = (m_pend < 255) ? m_pend + 1 : 255;
      else         pend_n = m_pend;
      run    = !hs && !ack && (m_pend != 0);
      idle_n = run ? m_idle + 1 : 0;
      flag_n = ack ? 0 : (m_flag || (run && idle_n >= TMO - 1));
      if (load) begin
         if (g >= 0) begin
            m_ov        = 1;
            m_word.ch   = CH_W'(g);
            m_word.data = bytes[g];
            m_ptr       = (g + 1) % NCH;
         end else begin
            m_ov = 0;
         end
      end
      m_pend = pend_n;
      m_idle = idle_n;
      m_flag = flag_n;
      m_irq  = irq_n;
      #1;
      checkOutput("out_valid", 32'(bus.out_valid), 32'(m_ov));
      checkOutput("out_data",  32'(bus.out_data),  32'(m_word));
      checkOutput("pending",   32'(pending),       32'(m_pend));
      checkOutput("irq",       32'(irq),           32'(m_irq));
   endtask

   // Guard against a stuck simulation
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios, then a random phase, then the summary
   initial begin
      int rise;
      bus.ch_valid  = '0;
      bus.ch_data   = '0;
      bus.out_ready = 1'b0;
      irq_enable    = 1'b0;
      irq_ack       = 1'b0;
      modelReset();

      // Reset state, including no pop strobe while held in reset
      bus.ch_valid = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ch_ready",  32'(bus.ch_ready),  0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
      checkOutput("rst_out_data",  32'(bus.out_data),  0);
      checkOutput("rst_irq",       32'(irq),           0);
      checkOutput("rst_pending",   32'(pending),       0);
      rst_n = 1'b1;

      // Stream, then pull reset mid-stream
      repeat (3) applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_ch_ready",  32'(bus.ch_ready),  0);
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 0);
      checkOutput("midrst_out_data",  32'(bus.out_data),  0);
      checkOutput("midrst_pending",   32'(pending),       0);
      checkOutput("midrst_irq",       32'(irq),           0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      modelReset();

      // First grant after reset is ch0, then fair rotation 1..7,0 at one word per cycle
      applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
      checkOutput("first_grant", 32'(bus.out_data[DW +: CH_W]), 0);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
         checkOutput("fair_tag",   32'(bus.out_data[DW +: CH_W]), k % 8);
         checkOutput("fair_valid", 32'(bus.out_valid), 1);
      end
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

      // Backpressure: ch3 byte 0x5A held for 5 stalled cycles, then accepted
      force_ch  = 3;
      force_val = 8'h5A;
      applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_load", 32'(bus.out_data), 32'({3'd3, 8'h5A}));
      for (int k = 0; k < 5; k++) begin
         applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
         checkOutput("bp_hold",  32'(bus.out_data),  32'({3'd3, 8'h5A}));
         checkOutput("bp_ready", 32'(bus.ch_ready),  0);
      end
      force_ch = -1;
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_drained", 32'(bus.out_valid), 0);

      // Pointer wrap: reach ptr=7 via ch6, then 0x81 gives 7 then 0; ptr=2 with 0x06 gives 2 then 1
      applyStimulus(8'h40, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
      checkOutput("wrap_ch7", 32'(bus.out_data[DW +: CH_W]), 7);
      applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
      checkOutput("wrap_ch0", 32'(bus.out_data[DW +: CH_W]), 0);
      applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h06, 1'b1, 1'b0, 1'b0);
      checkOutput("prio_ch2", 32'(bus.out_data[DW +: CH_W]), 2);
      applyStimulus(8'h06, 1'b1, 1'b0, 1'b0);
      checkOutput("prio_ch1", 32'(bus.out_data[DW +: CH_W]), 1);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

      // Threshold interrupt after the 16th delivery, then ack coinciding with a delivery
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b1);
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b1);
      checkOutput("ack_clear", 32'(pending), 0);
      for (int k = 0; k < 40 && m_pend != 16; k++)
         applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
      checkOutput("thr_count", 32'(pending), 16);
      checkOutput("thr_before", 32'(irq), 0);
      applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
      checkOutput("thr_irq", 32'(irq), 1);
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b1);
      checkOutput("ack_hs_pending", 32'(pending), 1);
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("ack_hs_irq", 32'(irq), 0);

      // Idle timeout: one word, then quiet; irq after TMO idle cycles, maskable, sticky
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b1);
      applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
      rise = 0;
      for (int n = 1; n <= 40 && rise == 0; n++) begin
         applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
         if (irq === 1'b1) rise = n;
      end
      checkOutput("timeout_cycles", 32'(rise), TMO);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
         checkOutput("masked_irq", 32'(irq), 0);
      end
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
      checkOutput("reenable_irq", 32'(irq), 1);

      // Pending counter saturates at its maximum
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 262; k++)
         applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
      checkOutput("sat_pending", 32'(pending), 255);
      applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
      checkOutput("sat_hold", 32'(pending), 255);

      // Random traffic, backpressure, masking and acknowledges
      for (int k = 0; k < 400; k++) begin
         applyStimulus(NCH'($urandom),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 15) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
